// File: rtl/ps2_cmd_scheduler.sv
// Round-robin host-to-device command scheduler for a PS/2 engine: sends command (+ optional
// parameter) bytes with per-byte ACK/RESEND/timeout handling and forwards all other rx bytes.
module ps2_cmd_scheduler #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_TIMEOUT = 502500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_cmd,
  input  logic [8*NUM_REQ-1:0]   req_param,
  input  logic [NUM_REQ-1:0]     req_has_param,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   dev_write,
  output logic [7:0]             dev_tx_data,
  input  logic                   dev_busy,
  input  logic                   dev_read,
  input  logic [7:0]             dev_rx_data,
  output logic                   rx_valid,
  output logic [7:0]             rx_byte
);

  localparam int unsigned TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;
  localparam logic [7:0] RESEND_BYTE = 8'hFE;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_TX, WAIT_ACK, FINISH} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d, param_q, param_d;
  logic              has_param_q, has_param_d, phase_q, phase_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GW-1:0]     grant_q, grant_d, rr_q, rr_d;
  logic [1:0]        busy_cnt_q, busy_cnt_d;
  logic [NUM_REQ-1:0] done_d, err_d;
  logic              dev_write_d, rx_valid_d;
  logic [7:0]        tx_data_d, rx_byte_d;

  logic              grant_found;
  logic [GW-1:0]     grant_idx;
  logic              is_ack, is_resend, timed_out, retry_max;

  assign is_ack    = dev_read && (dev_rx_data == ACK_BYTE);
  assign is_resend = dev_read && (dev_rx_data == RESEND_BYTE);
  assign timed_out = (timer_q == TW'(ACK_TIMEOUT));
  assign retry_max = (retry_q == RW'(MAX_RETRY));

  // First requester at or after the round-robin pointer, wrapping
  always_comb begin
    int unsigned k;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(rr_q) + i) % NUM_REQ;
      if (!grant_found && req[GW'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_found) state_d = SEND;
      SEND:      if (!dev_busy) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (dev_busy)                 state_d = WAIT_TX;
        else if (busy_cnt_q == 2'd3)  state_d = SEND;
      end
      WAIT_TX:   if (!dev_busy) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (is_ack)                       state_d = (!phase_q && has_param_q) ? SEND : FINISH;
        else if (is_resend || timed_out)  state_d = retry_max ? FINISH : SEND;
      end
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cmd_d       = cmd_q;
    param_d     = param_q;
    has_param_d = has_param_q;
    phase_d     = phase_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    busy_cnt_d  = busy_cnt_q;
    done_d      = '0;
    err_d       = '0;
    dev_write_d = 1'b0;
    tx_data_d   = dev_tx_data;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte;

    // ACK/RESEND are consumed only while an acknowledgement is awaited
    if (dev_read && !(state_q == WAIT_ACK && (is_ack || is_resend))) begin
      rx_valid_d = 1'b1;
      rx_byte_d  = dev_rx_data;
    end

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          grant_d     = grant_idx;
          cmd_d       = req_cmd[{grant_idx, 3'b000} +: 8];
          param_d     = req_param[{grant_idx, 3'b000} +: 8];
          has_param_d = req_has_param[grant_idx];
          phase_d     = 1'b0;
          retry_d     = '0;
        end
      end
      SEND: begin
        if (!dev_busy) begin
          dev_write_d = 1'b1;
          tx_data_d   = phase_q ? param_q : cmd_q;
          busy_cnt_d  = '0;
        end
      end
      WAIT_BUSY: if (!dev_busy) busy_cnt_d = busy_cnt_q + 2'd1;
      WAIT_TX:   if (!dev_busy) timer_d = '0;
      WAIT_ACK: begin
        timer_d = timer_q + TW'(1);
        if (is_ack) begin
          if (!phase_q && has_param_q) begin
            phase_d = 1'b1;
            retry_d = '0;
          end else begin
            done_d[grant_q] = 1'b1;
          end
        end else if (is_resend || timed_out) begin
          if (retry_max) err_d[grant_q] = 1'b1;
          else           retry_d = retry_q + RW'(1);
        end
      end
      FINISH: rr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      param_q     <= '0;
      has_param_q <= 1'b0;
      phase_q     <= 1'b0;
      retry_q     <= '0;
      timer_q     <= '0;
      grant_q     <= '0;
      rr_q        <= '0;
      busy_cnt_q  <= '0;
      done        <= '0;
      err         <= '0;
      dev_write   <= 1'b0;
      dev_tx_data <= '0;
      rx_valid    <= 1'b0;
      rx_byte     <= '0;
    end else begin
      cmd_q       <= cmd_d;
      param_q     <= param_d;
      has_param_q <= has_param_d;
      phase_q     <= phase_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      busy_cnt_q  <= busy_cnt_d;
      done        <= done_d;
      err         <= err_d;
      dev_write   <= dev_write_d;
      dev_tx_data <= tx_data_d;
      rx_valid    <= rx_valid_d;
      rx_byte     <= rx_byte_d;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: scripted PS/2 device model plus scoreboard queues for
// writes, done/err pulses and forwarded bytes.
module tb_ps2_cmd_scheduler;

  localparam int unsigned NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, req_has_param, done, err;
  logic [8*NREQ-1:0] req_cmd, req_param;
  logic              dev_write, dev_busy, dev_read, rx_valid;
  logic [7:0]        dev_tx_data, dev_rx_data, rx_byte;

  ps2_cmd_scheduler #(.NUM_REQ(NREQ), .MAX_RETRY(3), .ACK_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_param(req_param),
    .req_has_param(req_has_param), .done(done), .err(err), .dev_write(dev_write),
    .dev_tx_data(dev_tx_data), .dev_busy(dev_busy), .dev_read(dev_read),
    .dev_rx_data(dev_rx_data), .rx_valid(rx_valid), .rx_byte(rx_byte)
  );

  always #5 clk = ~clk;

  // resp: 10'h200 = stay silent, bit8 = send 0x1C before the low byte
  typedef struct packed {
    logic           idx;
    logic [7:0]     cmd;
    logic [7:0]     param;
    logic           has_param;
    logic [2:0]     nresp;
    logic [5:0][9:0] resp;
    logic [2:0]     nwr;
    logic [5:0][7:0] wr;
    logic           is_err;
    logic [8:0]     rx;
  } vec_t;

  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   inj_cnt = 0, inj_done = 0;
  logic [7:0] inj_byte;
  int   resp_q[$];
  int   exp_wr[$], exp_ev[$], exp_rx[$], wr_cyc[$];
  vec_t vecs[6];
  vec_t v;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1 dev_read = 1'b1; dev_rx_data = b;
    @(posedge clk);
    #1 dev_read = 1'b0;
  endtask

  // Device model: busy for 3 cycles after each write, then answers from resp_q
  initial begin : dev_model
    int r;
    dev_busy = 1'b0; dev_read = 1'b0; dev_rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      dev_read = 1'b0;
      if (dev_write) begin
        r = (resp_q.size() != 0) ? resp_q.pop_front() : 'h200;
        dev_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 dev_busy = 1'b0;
        if (r[9] == 1'b0) begin
          if (r[8]) send_byte(8'h1C);
          send_byte(8'(r));
        end
      end else if (inj_cnt != inj_done) begin
        dev_read = 1'b1; dev_rx_data = inj_byte; inj_done++;
      end
    end
  end

  // Scoreboard: every DUT output event must match the head of its queue
  initial begin : monitor
    logic [3:0] code;
    forever begin
      @(negedge clk);
      cyc++;
      if (dev_write) begin
        wr_cyc.push_back(cyc);
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL unexpected_write: got %0h", dev_tx_data);
        end else check("write_byte", 32'(dev_tx_data), 32'(exp_wr.pop_front()));
      end
      if (done != '0 || err != '0) begin
        code = {err, done};
        if (exp_ev.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL unexpected_done_err: got %0h", code);
        end else check("done_err", 32'(code), 32'(exp_ev.pop_front()));
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL unexpected_rx: got %0h", rx_byte);
        end else check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
      end
    end
  end

  task automatic wait_pulse(input string name, input int budget);
    int c = 0;
    while (done == '0 && err == '0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_timeout"}, 32'(c >= budget), 32'd0);
  endtask

  task automatic check_drained(input string name);
    check({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({name, "_ev_left"}, 32'(exp_ev.size()), 32'd0);
    check({name, "_rx_left"}, 32'(exp_rx.size()), 32'd0);
    check({name, "_resp_left"}, 32'(resp_q.size()), 32'd0);
  endtask

  task automatic outputs_zero(input string name);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_dev_write"}, 32'(dev_write), 32'd0);
    check({name, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({name, "_tx_data"}, 32'(dev_tx_data), 32'd0);
    check({name, "_rx_byte"}, 32'(rx_byte), 32'd0);
  endtask

  task automatic run_vec(input vec_t tv, input string name);
    for (int j = 0; j < int'(tv.nwr); j++) exp_wr.push_back(int'(tv.wr[j]));
    for (int j = 0; j < int'(tv.nresp); j++) resp_q.push_back(int'(tv.resp[j]));
    exp_ev.push_back(tv.is_err ? (4 << tv.idx) : (1 << tv.idx));
    if (tv.rx[8]) exp_rx.push_back(int'(tv.rx[7:0]));
    if (tv.idx) begin req_cmd[15:8] = tv.cmd; req_param[15:8] = tv.param; end
    else        begin req_cmd[7:0]  = tv.cmd; req_param[7:0]  = tv.param; end
    req_has_param[tv.idx] = tv.has_param;
    req[tv.idx] = 1'b1;
    wait_pulse(name, 2000);
    req = '0;
    // latched copy must be used: scramble inputs after completion is harmless
    req_cmd = 16'h5A5A;
    repeat (8) @(negedge clk);
    check_drained(name);
  endtask

  initial begin : main
    rst_n = 1'b0; req = '0; req_cmd = '0; req_param = '0; req_has_param = '0;
    inj_byte = 8'h00;
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vecs = '{default: '0};
    vecs[0].idx = 1'b0; vecs[0].cmd = 8'hF4; vecs[0].nresp = 3'd1; vecs[0].resp[0] = 10'h0FA;
    vecs[0].nwr = 3'd1; vecs[0].wr[0] = 8'hF4;
    vecs[1].idx = 1'b1; vecs[1].cmd = 8'hED; vecs[1].param = 8'h04; vecs[1].has_param = 1'b1;
    vecs[1].nresp = 3'd2; vecs[1].resp[0] = 10'h0FA; vecs[1].resp[1] = 10'h0FA;
    vecs[1].nwr = 3'd2; vecs[1].wr[0] = 8'hED; vecs[1].wr[1] = 8'h04;
    vecs[2].idx = 1'b0; vecs[2].cmd = 8'hF4; vecs[2].nresp = 3'd3;
    vecs[2].resp[0] = 10'h0FE; vecs[2].resp[1] = 10'h0FE; vecs[2].resp[2] = 10'h0FA;
    vecs[2].nwr = 3'd3; vecs[2].wr[0] = 8'hF4; vecs[2].wr[1] = 8'hF4; vecs[2].wr[2] = 8'hF4;
    vecs[3].idx = 1'b1; vecs[3].cmd = 8'hF3; vecs[3].param = 8'h0A; vecs[3].has_param = 1'b1;
    vecs[3].nresp = 3'd3; vecs[3].resp[0] = 10'h0FA; vecs[3].resp[1] = 10'h0FE; vecs[3].resp[2] = 10'h0FA;
    vecs[3].nwr = 3'd3; vecs[3].wr[0] = 8'hF3; vecs[3].wr[1] = 8'h0A; vecs[3].wr[2] = 8'h0A;
    vecs[4].idx = 1'b0; vecs[4].cmd = 8'hF4; vecs[4].nresp = 3'd1; vecs[4].resp[0] = 10'h1FA;
    vecs[4].nwr = 3'd1; vecs[4].wr[0] = 8'hF4; vecs[4].rx = 9'h11C;
    vecs[5].idx = 1'b1; vecs[5].cmd = 8'hED; vecs[5].param = 8'h02; vecs[5].has_param = 1'b1;
    vecs[5].nresp = 3'd6; vecs[5].resp[0] = 10'h0FE; vecs[5].resp[1] = 10'h0FA;
    for (int j = 2; j < 6; j++) vecs[5].resp[j] = 10'h200;
    vecs[5].nwr = 3'd6; vecs[5].wr[0] = 8'hED; vecs[5].wr[1] = 8'hED;
    for (int j = 2; j < 6; j++) vecs[5].wr[j] = 8'h02;
    vecs[5].is_err = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held: grants alternate 0,1,0,1
    req_cmd = 16'hF5F4; req_has_param = '0;
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back((i % 2 == 0) ? 'hF4 : 'hF5);
      exp_ev.push_back((i % 2 == 0) ? 1 : 2);
      resp_q.push_back('h0FA);
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_pulse($sformatf("rr%0d", i), 2000);
      if (i == 3) req = '0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check_drained("rr");

    // Unsolicited byte while idle is forwarded
    exp_rx.push_back('hAA);
    inj_byte = 8'hAA; inj_cnt++;
    repeat (6) @(negedge clk);
    check("idle_fwd_left", 32'(exp_rx.size()), 32'd0);

    // Silent device: four timeouts then err, writes spaced by at least ACK_TIMEOUT
    wr_cyc.delete();
    v = '0; v.idx = 1'b0; v.cmd = 8'hF5; v.nresp = 3'd4; v.nwr = 3'd4; v.is_err = 1'b1;
    for (int j = 0; j < 4; j++) begin v.resp[j] = 10'h200; v.wr[j] = 8'hF5; end
    run_vec(v, "timeout");
    check("timeout_nwr", 32'(wr_cyc.size()), 32'd4);
    for (int j = 1; j < wr_cyc.size(); j++)
      check($sformatf("timeout_gap%0d", j), 32'(wr_cyc[j] - wr_cyc[j-1] >= 100), 32'd1);

    // Reset while waiting for an ACK: nothing reported, next request served
    exp_wr.push_back('hF2); resp_q.push_back('h200);
    req_cmd[7:0] = 8'hF2; req_has_param = '0; req[0] = 1'b1;
    for (int c = 0; c < 50 && exp_wr.size() != 0; c++) @(negedge clk);
    check("rst_write_seen", 32'(exp_wr.size()), 32'd0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 outputs_zero("midrst");
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v = '0; v.idx = 1'b1; v.cmd = 8'hF4; v.nresp = 3'd1; v.resp[0] = 10'h0FA;
    v.nwr = 3'd1; v.wr[0] = 8'hF4;
    run_vec(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
